// File: rtl/seg7_capture_32.sv
// Capture side of an 8-digit multiplexed 7-segment display: synchronises the
// active-low anode/cathode lines, waits for them to settle and rebuilds the 32-bit word.
module seg7_capture_32 #(
    parameter int SETTLE_CLOCKS = 16
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [7:0]  i_an,
    input  logic [6:0]  i_seg,
    output logic [31:0] o_bits,
    output logic        o_valid,
    output logic [7:0]  o_digit_mask,
    output logic        o_err
);

    localparam int CW = $clog2(SETTLE_CLOCKS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CLOCKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CLOCKS - 1);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // Returns {legal, nibble} for an active-low {CA..CG} pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h01:   r = 5'h10;
            7'h4F:   r = 5'h11;
            7'h12:   r = 5'h12;
            7'h06:   r = 5'h13;
            7'h4C:   r = 5'h14;
            7'h24:   r = 5'h15;
            7'h20:   r = 5'h16;
            7'h0F:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h04:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h60:   r = 5'h1B;
            7'h31:   r = 5'h1C;
            7'h42:   r = 5'h1D;
            7'h30:   r = 5'h1E;
            7'h38:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] zero_count(input logic [7:0] an);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) n = n + 4'd1;
            else        n = n;
        end
        return n;
    endfunction

    function automatic logic [2:0] zero_index(input logic [7:0] an);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) idx = 3'(i);
            else        idx = idx;
        end
        return idx;
    endfunction

    logic [14:0]   sync1_r;
    logic [14:0]   sync2_r;
    logic [14:0]   prev_r;
    logic [CW-1:0] cnt_r;
    state_t        state_r;
    state_t        state_s;
    logic          changed_s;
    logic          sample_s;
    logic [7:0]    an_s;
    logic [6:0]    seg_s;
    logic [4:0]    dec_s;
    logic [3:0]    zeros_s;
    logic [2:0]    idx_s;
    logic          capture_s;
    logic          err_s;
    logic          commit_s;
    logic [7:0]    mask_next_s;
    logic [31:0]   shadow_next_s;
    logic [31:0]   shadow_r;

    assign changed_s = (sync2_r != prev_r);
    assign an_s      = sync2_r[14:7];
    assign seg_s     = sync2_r[6:0];
    assign dec_s     = seg_decode(seg_s);
    assign zeros_s   = zero_count(an_s);
    assign idx_s     = zero_index(an_s);

    // Two-flop synchroniser; resets to the blank pattern so reset never looks like a digit.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_r <= 15'h7FFF;
            sync2_r <= 15'h7FFF;
        end else begin
            sync1_r <= {i_an, i_seg};
            sync2_r <= sync1_r;
        end
    end

    // One-cycle-old copy of the synchronised inputs for change detection.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) prev_r <= 15'h7FFF;
        else       prev_r <= sync2_r;
    end

    // Settle counter: restarts on any change, saturates once the window is complete.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)                 cnt_r <= '0;
        else if (changed_s)        cnt_r <= '0;
        else if (cnt_r != CNT_MAX) cnt_r <= cnt_r + 1'b1;
        else                       cnt_r <= cnt_r;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) state_r <= ST_WAIT;
        else       state_r <= state_s;
    end

    // Next state: one sample per stable window, re-armed only by an input change.
    always_comb begin
        state_s  = state_r;
        sample_s = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (!changed_s && cnt_r == CNT_LAST) begin
                    sample_s = 1'b1;
                    state_s  = ST_HELD;
                end else begin
                    state_s  = ST_WAIT;
                end
            end
            ST_HELD: begin
                if (changed_s) state_s = ST_WAIT;
                else           state_s = ST_HELD;
            end
            default: state_s = ST_WAIT;
        endcase
    end

    // Classify the settled sample: blank, illegal, or a digit capture.
    always_comb begin
        capture_s = 1'b0;
        err_s     = 1'b0;
        if (sample_s) begin
            if (an_s == 8'hFF) begin
                capture_s = 1'b0;
            end else if (zeros_s != 4'd1) begin
                err_s = 1'b1;
            end else if (!dec_s[4]) begin
                err_s = 1'b1;
            end else begin
                capture_s = 1'b1;
            end
        end else begin
            capture_s = 1'b0;
        end
    end

    // Shadow/mask update; commit sees the nibble written on the same edge.
    always_comb begin
        shadow_next_s = shadow_r;
        shadow_next_s[{idx_s, 2'b00} +: 4] = dec_s[3:0];
        mask_next_s = o_digit_mask | (8'h01 << idx_s);
        commit_s    = capture_s && (mask_next_s == 8'hFF);
    end

    // Registered outputs and frame assembly.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_bits       <= 32'h0000_0000;
            o_valid      <= 1'b0;
            o_err        <= 1'b0;
            o_digit_mask <= 8'h00;
            shadow_r     <= 32'h0000_0000;
        end else begin
            o_valid <= commit_s;
            o_err   <= err_s;
            if (capture_s) begin
                shadow_r <= shadow_next_s;
                if (commit_s) begin
                    o_bits       <= shadow_next_s;
                    o_digit_mask <= 8'h00;
                end else begin
                    o_digit_mask <= mask_next_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture_32.sv
// Randomised and directed bench for seg7_capture_32 against an event-level
// model: each sufficiently long hold of a new input value is one sample.
module tb_seg7_capture_32;

    localparam int S = 16;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_an;
    logic [6:0]  i_seg;
    logic [31:0] o_bits;
    logic        o_valid;
    logic [7:0]  o_digit_mask;
    logic        o_err;

    always #5 clk = ~clk;

    seg7_capture_32 #(.SETTLE_CLOCKS(S)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_an         (i_an),
        .i_seg        (i_seg),
        .o_bits       (o_bits),
        .o_valid      (o_valid),
        .o_digit_mask (o_digit_mask),
        .o_err        (o_err)
    );

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef struct {
        int         at;
        logic [7:0] an;
        logic [6:0] seg;
    } ev_t;

    ev_t         pend [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          edge_cnt = 0;
    int          n_valid = 0;
    int          n_err = 0;
    int          last_valid_edge = 0;
    logic [3:0]  m_shadow [8];
    logic [7:0]  m_mask;
    logic [31:0] m_bits;
    logic [14:0] last_drv;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_cnt, got, exp);
        end
    endtask

    function automatic int seg_lookup(input logic [6:0] seg);
        for (int i = 0; i < 16; i++)
            if (SEG_TAB[i] == seg) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_shadow[i] = 4'h0;
        m_mask = 8'h00;
        m_bits = 32'h0;
        pend.delete();
    endtask

    // One clock: apply any sample due at this edge to the model, then compare outputs.
    task automatic tick();
        logic exp_v;
        logic exp_e;
        ev_t  ev;
        int   nib;
        int   k;
        @(posedge clk);
        edge_cnt++;
        #1;
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (pend.size() > 0 && pend[0].at == edge_cnt) begin
            ev  = pend.pop_front();
            nib = seg_lookup(ev.seg);
            if (ev.an == 8'hFF) begin
                exp_e = 1'b0;
            end else if ($countones(~ev.an) != 1) begin
                exp_e = 1'b1;
            end else if (nib < 0) begin
                exp_e = 1'b1;
            end else begin
                k = 0;
                for (int i = 0; i < 8; i++) if (!ev.an[i]) k = i;
                m_shadow[k] = nib[3:0];
                m_mask[k]   = 1'b1;
                if (m_mask == 8'hFF) begin
                    for (int i = 0; i < 8; i++) m_bits[4*i +: 4] = m_shadow[i];
                    m_mask = 8'h00;
                    exp_v  = 1'b1;
                end
            end
        end
        if (o_valid) begin
            n_valid++;
            last_valid_edge = edge_cnt;
        end
        if (o_err) n_err++;
        check_eq("valid", o_valid, exp_v);
        check_eq("err", o_err, exp_e);
        check_eq("mask", o_digit_mask, m_mask);
        check_eq("bits", o_bits, m_bits);
    endtask

    // Drive a value before the next edge and hold it for dur clocks.
    task automatic do_step(input logic [7:0] an, input logic [6:0] seg, input int dur);
        ev_t ev;
        i_an  = an;
        i_seg = seg;
        if ({an, seg} != last_drv && dur >= S + 1) begin
            ev.at  = edge_cnt + 1 + 2 + S;
            ev.an  = an;
            ev.seg = seg;
            pend.push_back(ev);
        end
        last_drv = {an, seg};
        repeat (dur) tick();
    endtask

    task automatic do_reset();
        i_an     = 8'hFF;
        i_seg    = 7'h7F;
        last_drv = 15'h7FFF;
        i_rst    = 1'b1;
        model_reset();
        #1;
        check_eq("rst_bits", o_bits, 32'h0);
        check_eq("rst_valid", o_valid, 1'b0);
        check_eq("rst_err", o_err, 1'b0);
        check_eq("rst_mask", o_digit_mask, 8'h00);
        repeat (3) begin
            @(posedge clk);
            edge_cnt++;
        end
        #1;
        check_eq("rst_hold_bits", o_bits, 32'h0);
        check_eq("rst_hold_mask", o_digit_mask, 8'h00);
        i_rst = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] word, input int dur);
        for (int k = 0; k < 8; k++)
            do_step(~(8'h01 << k), SEG_TAB[word[4*k +: 4]], dur);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  an;
        logic [6:0]  seg;
        int          dur;
        int          v0;
        int          e0;
        int          d7_edge;

        i_rst = 1'b0;
        i_an  = 8'hFF;
        i_seg = 7'h7F;
        #1;
        do_reset();
        repeat (S + 4) tick();

        // In-order frame with latency check on the last digit.
        v0 = n_valid;
        w  = 32'h89ABCDEF;
        for (int k = 0; k < 7; k++) do_step(~(8'h01 << k), SEG_TAB[w[4*k +: 4]], 40);
        d7_edge = edge_cnt + 1;
        do_step(8'h7F, SEG_TAB[w[31:28]], 40);
        check_eq("frame_bits", o_bits, 32'h89ABCDEF);
        check_eq("frame_valid_count", n_valid - v0, 1);
        check_eq("frame_latency", last_valid_edge - d7_edge, S + 2);
        do_step(8'hFF, 7'h7F, 40);

        // Short glitch on digit 3 must not be sampled.
        e0 = n_err;
        do_step(8'hF7, 7'h06, 40);
        do_step(8'hF7, 7'h12, 5);
        do_step(8'hF7, 7'h06, 40);
        check_eq("glitch_mask3", o_digit_mask[3], 1'b1);
        check_eq("glitch_err", n_err - e0, 0);

        // Illegal segment code, illegal anode, then blank.
        e0 = n_err;
        do_step(8'hFB, 7'h7F, 40);
        check_eq("illegal_seg_err", n_err - e0, 1);
        check_eq("illegal_seg_mask", o_digit_mask, 8'h08);
        do_step(8'hFC, 7'h01, 40);
        check_eq("illegal_an_err", n_err - e0, 2);
        do_step(8'hFF, 7'h7F, 40);
        check_eq("blank_err", n_err - e0, 2);
        v0 = n_valid;
        send_frame(32'h13579BDF, 40);
        check_eq("post_err_bits", o_bits, 32'h13579BDF);
        check_eq("post_err_valid", n_valid - v0, 1);

        // Out-of-order digits with digit 5 overwritten.
        v0 = n_valid;
        do_step(8'h7F, SEG_TAB[7], 40);
        do_step(8'hFE, SEG_TAB[0], 40);
        do_step(8'hDF, SEG_TAB[1], 40);
        do_step(8'hDF, SEG_TAB[14], 40);
        do_step(8'hFD, SEG_TAB[1], 40);
        do_step(8'hFB, SEG_TAB[2], 40);
        do_step(8'hF7, SEG_TAB[3], 40);
        do_step(8'hEF, SEG_TAB[4], 40);
        do_step(8'hBF, SEG_TAB[6], 40);
        check_eq("ooo_bits", o_bits, 32'h76E43210);
        check_eq("ooo_valid", n_valid - v0, 1);

        // Dwell boundary: S clocks is too short, S+1 is sampled.
        do_step(8'hFE, 7'h01, S);
        do_step(8'hFE, 7'h4F, S + 1);
        do_step(8'hFF, 7'h7F, 40);

        // Reset after four captured digits.
        send_frame(32'hFFFF0000, 40);
        for (int k = 0; k < 4; k++) do_step(~(8'h01 << k), SEG_TAB[k], 40);
        check_eq("pre_rst_mask", o_digit_mask, 8'h0F);
        do_reset();
        v0 = n_valid;
        send_frame(32'hCAFE1234, 40);
        check_eq("post_rst_bits", o_bits, 32'hCAFE1234);
        check_eq("post_rst_valid", n_valid - v0, 1);

        // Randomised holds: mostly legal digits, some blanks, glitches and illegal codes.
        for (int n = 0; n < 160; n++) begin
            do begin
                case ($urandom_range(0, 9))
                    0:       an = 8'hFF;
                    1:       an = 8'($urandom_range(0, 255));
                    default: an = ~(8'h01 << $urandom_range(0, 7));
                endcase
                if ($urandom_range(0, 7) == 0) seg = 7'($urandom_range(0, 127));
                else                           seg = SEG_TAB[$urandom_range(0, 15)];
            end while ({an, seg} == last_drv);
            if ($urandom_range(0, 3) == 0) dur = $urandom_range(1, S);
            else                           dur = $urandom_range(S + 1, S + 12);
            do_step(an, seg, dur);
            if (n == 80) do_reset();
        end
        do_step(8'hFF, 7'h7F, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
